// File: rtl/hc595_chain_driver.sv
// Serialises an N_CHIPS x 8-bit word into a cascade of 74HC595 shift registers,
// generating SER/SRCLK/RCLK/OE_n from a start/ready handshake.
module hc595_chain_driver #(
    parameter int N_CHIPS     = 2,
    parameter int HALF_PERIOD = 500,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [8*N_CHIPS-1:0]   data,
    output logic                   ready,
    output logic                   done,
    output logic                   ser,
    output logic                   srclk,
    output logic                   rclk,
    output logic                   oe_n
);
    localparam int W  = 8 * N_CHIPS;
    localparam int BW = $clog2(W);
    localparam int TW = $clog2(HALF_PERIOD) + 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH_SU,
        LATCH
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [W-1:0]  sreg_q, sreg_d;
    logic          ser_q, ser_d;
    logic          srclk_q, srclk_d;
    logic          rclk_q, rclk_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          oe_n_q, oe_n_d;
    logic          phase_end;

    function automatic logic first_bit(input logic [W-1:0] v);
        return MSB_FIRST ? v[W-1] : v[0];
    endfunction

    function automatic logic [W-1:0] advance(input logic [W-1:0] v);
        return MSB_FIRST ? (v << 1) : (v >> 1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            bit_q   <= '0;
            sreg_q  <= '0;
            ser_q   <= 1'b0;
            srclk_q <= 1'b0;
            rclk_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            oe_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            sreg_q  <= sreg_d;
            ser_q   <= ser_d;
            srclk_q <= srclk_d;
            rclk_q  <= rclk_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            oe_n_q  <= oe_n_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        bit_d     = bit_q;
        sreg_d    = sreg_q;
        oe_n_d    = oe_n_q;
        done_d    = 1'b0;
        phase_end = (tmr_q == TMR_LAST);

        if (state_q != IDLE) begin
            tmr_d = phase_end ? '0 : tmr_q + TW'(1);
        end

        case (state_q)
            IDLE: begin
                if (start && ready_q) begin
                    sreg_d  = data;
                    bit_d   = '0;
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (phase_end) state_d = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = LATCH_SU;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        sreg_d  = advance(sreg_q);
                        state_d = SHIFT_LO;
                    end
                end
            end
            LATCH_SU: begin
                if (phase_end) state_d = LATCH;
            end
            LATCH: begin
                if (phase_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    oe_n_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pins are registered from the next state, so each one changes exactly on a phase edge.
        ser_d   = first_bit(sreg_d);
        srclk_d = (state_d == SHIFT_HI);
        rclk_d  = (state_d == LATCH);
        ready_d = (state_d == IDLE);
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign ser   = ser_q;
    assign srclk = srclk_q;
    assign rclk  = rclk_q;
    assign oe_n  = oe_n_q;

endmodule

// File: tb/tb_hc595_chain_driver.sv
// Scoreboard bench: a board-level 74HC595 chain model observes the pins of three
// driver instances and compares latched contents against queued expectations.
module tb_hc595_chain_driver;
    localparam int WI [3] = '{16, 16, 24};
    localparam int HI [3] = '{2, 2, 1};
    localparam int MI [3] = '{1, 0, 1};
    localparam int LIMIT  = 5000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start_v = '0;
    logic [31:0] data_v [3];
    logic [2:0]  ready_w, done_w, ser_w, srclk_w, rclk_w, oe_w;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q [3][$];

    int          src_cnt [3];
    int          rck_cnt [3];
    int          rck_w   [3];
    int          rdy_lo  [3];
    logic [31:0] chain   [3];
    logic [31:0] latched [3];
    logic [2:0]  prev_srclk, prev_rclk, prev_done;

    always #5 clk = ~clk;

    hc595_chain_driver #(.N_CHIPS(2), .HALF_PERIOD(2), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .data(data_v[0][15:0]),
        .ready(ready_w[0]), .done(done_w[0]), .ser(ser_w[0]), .srclk(srclk_w[0]),
        .rclk(rclk_w[0]), .oe_n(oe_w[0]));

    hc595_chain_driver #(.N_CHIPS(2), .HALF_PERIOD(2), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .data(data_v[1][15:0]),
        .ready(ready_w[1]), .done(done_w[1]), .ser(ser_w[1]), .srclk(srclk_w[1]),
        .rclk(rclk_w[1]), .oe_n(oe_w[1]));

    hc595_chain_driver #(.N_CHIPS(3), .HALF_PERIOD(1), .MSB_FIRST(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .data(data_v[2][23:0]),
        .ready(ready_w[2]), .done(done_w[2]), .ser(ser_w[2]), .srclk(srclk_w[2]),
        .rclk(rclk_w[2]), .oe_n(oe_w[2]));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    // What the cascade's storage register should show once the word is latched.
    function automatic logic [31:0] latch_pattern(input int i, input logic [31:0] d);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < WI[i]; k++)
            r[k] = (MI[i] != 0) ? d[k] : d[WI[i]-1-k];
        return r;
    endfunction

    // Monitor: model the shift/storage registers of the chip chain from the pins.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                src_cnt[i] = 0; rck_cnt[i] = 0; rck_w[i] = 0; rdy_lo[i] = 0;
                chain[i] = '0; latched[i] = '0;
                exp_q[i].delete();
            end else begin
                if (srclk_w[i] && !prev_srclk[i]) begin
                    chain[i] = (chain[i] << 1) | {31'd0, ser_w[i]};
                    src_cnt[i]++;
                end
                if (rclk_w[i] && !prev_rclk[i]) begin
                    latched[i] = chain[i];
                    rck_cnt[i]++;
                end
                if (rclk_w[i]) rck_w[i]++;
                if (!ready_w[i]) rdy_lo[i]++;
                if (done_w[i]) begin
                    logic [31:0] m;
                    logic [31:0] e;
                    m = (32'h1 << WI[i]) - 32'h1;
                    chk($sformatf("done_expected[%0d]", i), 32'(exp_q[i].size() > 0), 32'd1);
                    if (exp_q[i].size() > 0) begin
                        e = exp_q[i].pop_front();
                        chk($sformatf("latched_word[%0d]", i), latched[i] & m, e);
                    end
                    chk($sformatf("srclk_rises[%0d]", i), src_cnt[i], WI[i]);
                    chk($sformatf("rclk_rises[%0d]", i), rck_cnt[i], 1);
                    chk($sformatf("rclk_width[%0d]", i), rck_w[i], HI[i]);
                    chk($sformatf("ready_low_clks[%0d]", i), rdy_lo[i], (2*WI[i]+2)*HI[i]);
                    chk($sformatf("oe_n_at_done[%0d]", i), oe_w[i], 0);
                    chk($sformatf("ready_at_done[%0d]", i), ready_w[i], 1);
                    chk($sformatf("done_single_cycle[%0d]", i), prev_done[i], 0);
                    src_cnt[i] = 0; rck_cnt[i] = 0; rck_w[i] = 0; rdy_lo[i] = 0;
                end
            end
            prev_srclk[i] = srclk_w[i];
            prev_rclk[i]  = rclk_w[i];
            prev_done[i]  = done_w[i];
        end
    end

    task automatic wait_ready(input int i);
        int n = 0;
        while (!ready_w[i] && n < LIMIT) begin @(negedge clk); n++; end
        if (n >= LIMIT) chk($sformatf("ready_timeout[%0d]", i), ready_w[i], 1);
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while (!(ready_w[i] && exp_q[i].size() == 0) && n < LIMIT) begin @(negedge clk); n++; end
        if (n >= LIMIT) chk($sformatf("idle_timeout[%0d]", i), 32'(exp_q[i].size()), 0);
    endtask

    task automatic send(input int i, input logic [31:0] d);
        wait_ready(i);
        data_v[i]  = d;
        start_v[i] = 1'b1;
        exp_q[i].push_back(latch_pattern(i, d));
        @(negedge clk);
        start_v[i] = 1'b0;
        data_v[i]  = $urandom;
    endtask

    task automatic b2b(input int i, input logic [31:0] d1, input logic [31:0] d2);
        int n = 0;
        wait_ready(i);
        data_v[i]  = d1;
        start_v[i] = 1'b1;
        exp_q[i].push_back(latch_pattern(i, d1));
        @(negedge clk);
        while (!done_w[i] && n < LIMIT) begin @(negedge clk); n++; end
        chk($sformatf("b2b_done_seen[%0d]", i), done_w[i], 1);
        data_v[i] = d2;
        exp_q[i].push_back(latch_pattern(i, d2));
        @(negedge clk);
        chk($sformatf("b2b_no_gap[%0d]", i), ready_w[i], 0);
        start_v[i] = 1'b0;
        data_v[i]  = $urandom;
    endtask

    initial begin
        int n;
        logic saw_rclk;
        for (int i = 0; i < 3; i++) data_v[i] = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ready[%0d]", i), ready_w[i], 1);
            chk($sformatf("rst_done[%0d]", i),  done_w[i],  0);
            chk($sformatf("rst_ser[%0d]", i),   ser_w[i],   0);
            chk($sformatf("rst_srclk[%0d]", i), srclk_w[i], 0);
            chk($sformatf("rst_rclk[%0d]", i),  rclk_w[i],  0);
            chk($sformatf("rst_oe_n[%0d]", i),  oe_w[i],    1);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // First transfer: outputs stay disabled until its latch completes.
        send(0, 32'h0000A5C3);
        repeat (10) @(negedge clk);
        chk("busy_ready_low", ready_w[0], 0);
        chk("oe_n_before_first_latch", oe_w[0], 1);
        wait_idle(0);
        chk("oe_n_after_first_latch", oe_w[0], 0);

        send(1, 32'h0000A5C3);
        wait_idle(1);

        // Start while busy must be ignored.
        send(0, 32'h0000A5C3);
        repeat (20) @(negedge clk);
        data_v[0]  = 32'h0000FFFF;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("busy_start_ignored_ready", ready_w[0], 0);
        wait_idle(0);

        b2b(0, 32'h00000001, 32'h00008000);
        wait_idle(0);

        send(2, 32'h00123456);
        wait_idle(2);

        for (int r = 0; r < 9; r++) begin
            int i;
            i = r % 3;
            if ($urandom_range(0, 1) == 1) b2b(i, $urandom, $urandom);
            else send(i, $urandom);
            wait_idle(i);
        end

        // Reset in the middle of a transfer aborts it without a latch pulse.
        send(0, 32'h00005AA5);
        n = 0;
        while (src_cnt[0] < 5 && n < LIMIT) begin @(negedge clk); n++; end
        chk("abort_reached_5_rises", 32'(src_cnt[0] >= 5), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ready", ready_w[0], 1);
        chk("abort_done",  done_w[0],  0);
        chk("abort_ser",   ser_w[0],   0);
        chk("abort_srclk", srclk_w[0], 0);
        chk("abort_rclk",  rclk_w[0],  0);
        chk("abort_oe_n",  oe_w[0],    1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        saw_rclk = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rclk_w[0]) saw_rclk = 1'b1;
        end
        chk("abort_no_rclk_after", saw_rclk, 0);
        chk("abort_oe_n_held", oe_w[0], 1);
        send(0, 32'h00003C5A);
        wait_idle(0);
        chk("recover_oe_n", oe_w[0], 0);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, got=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
